// File: rtl/fma16_pkg.sv
// Shared fma16 types: FSM state, half-precision field layout, bias and an unpacking helper.
package fma16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int SIGN_BIT   = 15;
   localparam int EXP_HI     = 14;
   localparam int EXP_LO     = 10;
   localparam int FRAC_HI    = 9;
   localparam int FRAC_LO    = 0;
   localparam int HALF_BIAS  = 15;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } half_t;

   function automatic half_t unpack_half(input logic [15:0] h);
      half_t r;
      r.sign = h[SIGN_BIT];
      r.exp  = h[EXP_HI:EXP_LO];
      r.frac = h[FRAC_HI:FRAC_LO];
      return r;
   endfunction

endpackage

// File: rtl/fma16_shift_add_step.sv
// One radix-2 shift-add iteration: conditional add into the upper half, then shift right by one.
module fma16_shift_add_step #(
   parameter int MANT_W = 11
) (
   input  logic [2*MANT_W-1:0] acc,
   input  logic [MANT_W-1:0]   mcand,
   input  logic [MANT_W-1:0]   mplr,
   output logic [2*MANT_W-1:0] acc_next,
   output logic [MANT_W-1:0]   mplr_next
);

   logic [MANT_W:0] sum;

   always_comb begin
      sum = {1'b0, acc[2*MANT_W-1:MANT_W]};
      if (mplr[0]) begin
         sum = sum + {1'b0, mcand};
      end
   end

   // The carry-out becomes the new MSB after the shift.
   assign acc_next  = {sum, acc[MANT_W-1:1]};
   assign mplr_next = {1'b0, mplr[MANT_W-1:1]};

endmodule

// File: rtl/fma16_mult_seq.sv
// Sequential half-precision significand multiplier feeding the fma16 align-and-sum stage.
// Optional zero/early-termination shortcut enabled by defining FMA16_MULT_EARLY_OUT_EN.
module fma16_mult_seq
   import fma16_pkg::*;
#(
   parameter int MANT_W = 11,
   parameter int BIAS   = HALF_BIAS,
   parameter int EXP_W  = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [15:0]         x,
   input  logic [15:0]         y,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                xs,
   output logic                ys,
   output logic                ps,
   output logic [EXP_W-1:0]    xe,
   output logic [EXP_W-1:0]    ye,
   output logic [EXP_W:0]      pe,
   output logic [2*MANT_W-1:0] mid_pm,
   output logic                x_zero,
   output logic                y_zero
);

   localparam int CNT_W = $clog2(MANT_W);
   localparam logic [EXP_W:0] BIAS_V = (EXP_W+1)'(BIAS);

   mult_state_t         state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [MANT_W-1:0]   mcand_reg, mplr_reg;
   logic [2*MANT_W-1:0] acc_reg;
   logic                in_ready_reg, out_valid_reg;
   logic                xs_reg, ys_reg, ps_reg, xz_reg, yz_reg;
   logic [EXP_W-1:0]    xe_reg, ye_reg;
   logic [EXP_W:0]      pe_reg;

   half_t               xh, yh;
   logic [EXP_W:0]      pe_calc;
   logic                xz_calc, yz_calc;
   logic [2*MANT_W-1:0] acc_step;
   logic [MANT_W-1:0]   mplr_step;

   assign xh      = unpack_half(x);
   assign yh      = unpack_half(y);
   assign pe_calc = (EXP_W+1)'(xh.exp) + (EXP_W+1)'(yh.exp) - BIAS_V;
   assign xz_calc = ({xh.exp, xh.frac} == '0);
   assign yz_calc = ({yh.exp, yh.frac} == '0);

   fma16_shift_add_step #(.MANT_W(MANT_W)) u_step (
      .acc       (acc_reg),
      .mcand     (mcand_reg),
      .mplr      (mplr_reg),
      .acc_next  (acc_step),
      .mplr_next (mplr_step)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         mcand_reg     <= '0;
         mplr_reg      <= '0;
         acc_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         xs_reg        <= 1'b0;
         ys_reg        <= 1'b0;
         ps_reg        <= 1'b0;
         xe_reg        <= '0;
         ye_reg        <= '0;
         pe_reg        <= '0;
         xz_reg        <= 1'b0;
         yz_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  xs_reg       <= xh.sign;
                  ys_reg       <= yh.sign;
                  ps_reg       <= xh.sign ^ yh.sign;
                  xe_reg       <= EXP_W'(xh.exp);
                  ye_reg       <= EXP_W'(yh.exp);
                  pe_reg       <= pe_calc;
                  xz_reg       <= xz_calc;
                  yz_reg       <= yz_calc;
                  // Subnormals carry an implicit bit of 0.
                  mcand_reg    <= MANT_W'({xh.exp != 5'd0, xh.frac});
                  mplr_reg     <= MANT_W'({yh.exp != 5'd0, yh.frac});
                  acc_reg      <= '0;
                  cnt_reg      <= CNT_W'(MANT_W-1);
                  in_ready_reg <= 1'b0;
                  state_reg    <= MUL;
`ifdef FMA16_MULT_EARLY_OUT_EN
                  if (xz_calc || yz_calc) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                  end
`endif
               end
            end
            MUL: begin
               acc_reg  <= acc_step;
               mplr_reg <= mplr_step;
               cnt_reg  <= cnt_reg - 1'b1;
               if (cnt_reg == '0) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
`ifdef FMA16_MULT_EARLY_OUT_EN
               // No set bits left: the remaining iterations are pure shifts.
               else if (mplr_step == '0) begin
                  acc_reg       <= acc_step >> cnt_reg;
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign xs        = xs_reg;
   assign ys        = ys_reg;
   assign ps        = ps_reg;
   assign xe        = xe_reg;
   assign ye        = ye_reg;
   assign pe        = pe_reg;
   assign mid_pm    = acc_reg;
   assign x_zero    = xz_reg;
   assign y_zero    = yz_reg;

endmodule

// File: tb/tb_fma16_mult_seq.sv
// Self-checking bench for fma16_mult_seq: directed vector table, reset/back-pressure sequences, random ops vs model.
module tb_fma16_mult_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x, y;
   logic        out_valid;
   logic        out_ready;
   logic        xs, ys, ps;
   logic [4:0]  xe, ye;
   logic [5:0]  pe;
   logic [21:0] mid_pm;
   logic        x_zero, y_zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fma16_mult_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xs        (xs),
      .ys        (ys),
      .ps        (ps),
      .xe        (xe),
      .ye        (ye),
      .pe        (pe),
      .mid_pm    (mid_pm),
      .x_zero    (x_zero),
      .y_zero    (y_zero)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [21:0] pm;
      logic [5:0]  pe;
      logic        ps;
      int          hold;
   } vec_t;

   typedef struct {
      logic [21:0] pm;
      logic [5:0]  pe;
      logic        ps;
   } exp_t;

   // Reference: value-level significand product and wrapped exponent sum.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t r;
      int   ma, mb, ea, eb;
      ea   = int'(a[14:10]);
      eb   = int'(b[14:10]);
      ma   = ((ea != 0) ? 1024 : 0) + int'(a[9:0]);
      mb   = ((eb != 0) ? 1024 : 0) + int'(b[9:0]);
      r.pm = 22'(ma * mb);
      r.pe = 6'((ea + eb - 15 + 64) % 64);
      r.ps = a[15] ^ b[15];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [21:0] pm_e,
                        input logic [5:0] pe_e, input logic ps_e, input int hold);
      int lat;
      bit zero_op;
      zero_op = (a[14:0] == 15'd0) || (b[14:0] == 15'd0);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      x = a; y = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; x = 16'h0; y = 16'h0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
`ifdef FMA16_MULT_EARLY_OUT_EN
      if (zero_op) chk("latency_zero", lat, 0);
      else         chk("latency_le_max", lat <= 11, 1);
`else
      chk("latency", lat, 11);
`endif
      chk("out_valid", out_valid, 1);
      chk("mid_pm", mid_pm, pm_e);
      chk("pe", pe, pe_e);
      chk("ps", ps, ps_e);
      chk("xs", xs, a[15]);
      chk("ys", ys, b[15]);
      chk("xe", xe, a[14:10]);
      chk("ye", ye, b[14:10]);
      chk("x_zero", x_zero, a[14:0] == 15'd0);
      chk("y_zero", y_zero, b[14:0] == 15'd0);
      chk("in_ready_busy", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; x = 16'h4500; y = 16'h4600;
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_pm", mid_pm, pm_e);
         chk("hold_pe", pe, pe_e);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
      chk("no_recapture_xe", xe, a[14:10]);
      $display("[TB] op x=%04h y=%04h pm=%06h pe=%02h ps=%0d lat=%0d hold=%0d zero=%0d",
               a, b, pm_e, pe_e, ps_e, lat, hold, zero_op);
   endtask

   vec_t vecs[8];
   exp_t e;
   logic [15:0] ra, rb;

   initial begin
      vecs[0] = '{16'h3C00, 16'h4000, 22'h100000, 6'h10, 1'b0, 0};
      vecs[1] = '{16'h3E00, 16'h3E00, 22'h240000, 6'h0F, 1'b0, 0};
      vecs[2] = '{16'hBC00, 16'h3C00, 22'h100000, 6'h0F, 1'b1, 0};
      vecs[3] = '{16'h0400, 16'h0400, 22'h100000, 6'h33, 1'b0, 0};
      vecs[4] = '{16'h0001, 16'h3C00, 22'h000400, 6'h00, 1'b0, 0};
      vecs[5] = '{16'h4200, 16'hC400, 22'h180000, 6'h12, 1'b1, 5};
      vecs[6] = '{16'h0000, 16'h3C00, 22'h000000, 6'h00, 1'b0, 0};
      vecs[7] = '{16'h7BFF, 16'h7BFF, 22'h3FF001, 6'h2D, 1'b0, 1};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 16'h0; y = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mid_pm", mid_pm, 0);
      chk("rst_pe", pe, 0);
      reset_n = 1'b1;

      // out_ready while idle must not disturb anything.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_out_ready_valid", out_valid, 0);
      chk("idle_out_ready_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].pm, vecs[i].pe, vecs[i].ps, vecs[i].hold);
      end

      // Reset asserted during the fifth MUL cycle.
      @(negedge clk);
      x = 16'h3C00; y = 16'h3C00; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_mul_busy", in_ready, 0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_mid_pm", mid_pm, 0);
      chk("mid_rst_xe", xe, 0);
      chk("mid_rst_pe", pe, 0);
      $display("[TB] op reset during MUL cycle 5");
      do_op(16'h3C00, 16'h3C00, 22'h100000, 6'h0F, 1'b0, 0);

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 6 == 0) ra[14:0] = 15'd0;
         if (i % 7 == 3) rb[14:10] = 5'd0;
         e = model(ra, rb);
         do_op(ra, rb, e.pm, e.pe, e.ps, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
